// File: rtl/branch_pkg.sv
// Shared definitions for the branch/PC controller: branch function codes and
// the registered ALU flag set.
package branch_pkg;

  localparam logic [4:0] FC_B    = 5'd0;
  localparam logic [4:0] FC_BCY  = 5'd1;
  localparam logic [4:0] FC_BNCY = 5'd2;
  localparam logic [4:0] FC_BZ   = 5'd3;
  localparam logic [4:0] FC_BLTZ = 5'd4;
  localparam logic [4:0] FC_BNZ  = 5'd5;
  localparam logic [4:0] FC_CALL = 5'd6;
  localparam logic [4:0] FC_RET  = 5'd7;

  typedef struct packed {
    logic s;
    logic z;
    logic c;
  } flags_t;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// a pop from empty is ignored, and the count saturates at DEPTH.
module return_addr_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    top;  // next slot to write; newest entry sits at top-1

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign dout  = mem[top - PTR_ONE];

  // NOTE: storage has no reset; count/top alone define validity, so stale
  // contents are never observed and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) mem[top] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top   <= '0;
      count <= '0;
    end else if (push) begin
      top <= top + PTR_ONE;
      if (!full) count <= count + CNT_ONE;
    end else if (pop && !empty) begin
      top   <= top - PTR_ONE;
      count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Sequential branch/PC controller: owns the PC and flag registers, resolves
// conditional/call/return branches and drives the return-address stack.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               RAS_DEPTH = 4,
  parameter int               PC_STEP   = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter bit               REL_LABEL = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         branch,
  input  logic                         branch_src,
  input  logic [4:0]                   fcode,
  input  logic [WIDTH-1:0]             read_data1,
  input  logic [WIDTH-1:0]             label,
  input  logic                         flag_we,
  input  logic                         alu_sign,
  input  logic                         alu_zero,
  input  logic                         alu_carry,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             next_pc,
  output logic                         taken,
  output logic [WIDTH-1:0]             write_reg_data,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_unf
);

  flags_t           flags;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] ras_dout;
  logic             push_req, pop_req;
  logic             ras_push, ras_pop;
  logic             ras_full, ras_empty;

  assign pc_inc         = pc + WIDTH'(PC_STEP);
  assign write_reg_data = pc_inc;
  assign ras_push       = push_req && !stall;
  assign ras_pop        = pop_req && !stall;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    taken    = 1'b0;
    push_req = 1'b0;
    pop_req  = 1'b0;
    target   = branch_src ? read_data1 : (REL_LABEL ? pc + label : label);
    if (branch) begin
      case (fcode)
        FC_B:    taken = 1'b1;
        FC_BCY:  taken = flags.c;
        FC_BNCY: taken = !flags.c;
        FC_BZ:   taken = flags.z;
        FC_BLTZ: taken = flags.s;
        FC_BNZ:  taken = !flags.z;
        FC_CALL: begin
          taken    = 1'b1;
          push_req = 1'b1;
        end
        FC_RET: begin
          pop_req = 1'b1;
          taken   = !ras_empty;
          target  = ras_dout;
        end
        default: ;
      endcase
    end
    next_pc = taken ? target : pc_inc;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, e.g. a branch sees the flags from before flag_we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      flags   <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else if (!stall) begin
      pc <= next_pc;
      if (flag_we) flags <= '{s: alu_sign, z: alu_zero, c: alu_carry};
      if (ras_push && ras_full)  ras_ovf <= 1'b1;
      if (ras_pop  && ras_empty) ras_unf <= 1'b1;
    end
  end

  return_addr_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_inc),
    .dout  (ras_dout),
    .count (ras_count),
    .full  (ras_full),
    .empty (ras_empty)
  );

endmodule
